io_intc: RTL

IO_INTC -- requirements
Module: io_intc

---
 rtl/io_intc.sv | 127 ++++++++++++
 1 files changed

// File: rtl/io_intc.sv
// rtl/io_intc.sv - 8080 interrupt controller: edge-latched requests, mask, in-service nesting, RST n vector drive
// Vector is jammed onto the bus during the INTA read cycle; mask and EOI via OUT, pending/isr via IN.
module io_intc #(
  parameter int         XLEN      = 8,
  parameter logic [7:0] BASE_PORT = 8'h10
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            sync,
  input  logic            dbin,
  input  logic            write_n,
  input  logic [7:0]      io_addr,
  input  logic [XLEN-1:0] data_in,
  output logic [XLEN-1:0] data_out,
  output logic            data_oe,
  input  logic [7:0]      irq,
  output logic            iint
);

  // 8080 status byte bit positions
  localparam int ST_INTA = 0;
  localparam int ST_OUT  = 4;
  localparam int ST_INP  = 6;

  typedef enum logic [1:0] {IDLE, ACK, DRIVE} state_t;

  state_t     r_state;
  logic [7:0] r_status;
  logic [7:0] r_irq_prev;
  logic [7:0] r_pending;
  logic [7:0] r_mask;
  logic [7:0] r_isr;
  logic [2:0] r_vec;
  logic       r_spur;

  logic [7:0] w_rise;
  logic [7:0] w_req;
  logic [7:0] w_req_low;
  logic [7:0] w_isr_low;
  logic [7:0] w_clr;
  logic [7:0] w_isr_eoi;
  logic [2:0] w_cand;
  logic       w_cand_vld;
  logic       w_exit;
  logic       w_wr_mask;
  logic       w_wr_eoi;
  logic [7:0] w_bus;
  logic       w_unused;

  assign w_rise    = irq & ~r_irq_prev;
  assign w_req     = r_pending & ~r_mask;
  assign w_req_low = w_req & (~w_req + 8'd1);
  assign w_isr_low = r_isr & (~r_isr + 8'd1);
  // Clearing the lowest set bit; a no-op when isr is already zero
  assign w_isr_eoi = r_isr & (r_isr - 8'd1);

  always_comb begin
    w_cand_vld = 1'b0;
    w_cand     = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (w_req[i]) begin
        w_cand_vld = 1'b1;
        w_cand     = 3'(i);
      end
    end
  end

  // One-hot compare: a lower index is a numerically smaller one-hot value
  assign iint = w_cand_vld && (r_state == IDLE) &&
                ((r_isr == 8'd0) || (w_req_low < w_isr_low));

  assign w_exit    = (r_state == DRIVE) && !dbin && !r_spur;
  assign w_clr     = w_exit ? (8'd1 << r_vec) : 8'd0;
  assign w_wr_mask = r_status[ST_OUT] && !write_n && (io_addr == BASE_PORT);
  assign w_wr_eoi  = r_status[ST_OUT] && !write_n && (io_addr == BASE_PORT + 8'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_status   <= 8'd0;
      r_irq_prev <= 8'd0;
      r_pending  <= 8'd0;
      r_mask     <= 8'hFF;
      r_isr      <= 8'd0;
      r_vec      <= 3'd0;
      r_spur     <= 1'b0;
    end else begin
      r_irq_prev <= irq;
      if (sync) r_status <= data_in[7:0];
      // A fresh edge on the vector being retired keeps it pending
      r_pending <= (r_pending & ~w_clr) | w_rise;
      r_isr     <= (w_wr_eoi ? w_isr_eoi : r_isr) | w_clr;
      if (w_wr_mask) r_mask <= data_in[7:0];
      case (r_state)
        IDLE: begin
          if (sync && data_in[ST_INTA]) begin
            r_state <= ACK;
            r_vec   <= w_cand;
            r_spur  <= !w_cand_vld;
          end
        end
        ACK:     if (dbin)  r_state <= DRIVE;
        DRIVE:   if (!dbin) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  always_comb begin
    w_bus   = 8'd0;
    data_oe = 1'b0;
    if (r_state == DRIVE && dbin) begin
      data_oe = 1'b1;
      w_bus   = r_spur ? 8'hFF : (8'hC7 | {2'b00, r_vec, 3'b000});
    end else if (r_status[ST_INP] && dbin && io_addr == BASE_PORT) begin
      data_oe = 1'b1;
      w_bus   = r_pending;
    end else if (r_status[ST_INP] && dbin && io_addr == BASE_PORT + 8'd1) begin
      data_oe = 1'b1;
      w_bus   = r_isr;
    end
  end

  assign data_out = XLEN'(w_bus);
  assign w_unused = ^{r_status, data_in};

endmodule
